// File: rtl/pixel_feeder.sv
// pixel_feeder
// Gathers a raster-order pixel stream into two ping-pong row buffers. Each
// complete row is handed to a consumer, one row for each request.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   pix_valid  pix_data carries a pixel this cycle
//   pix_data   incoming pixel, raster order
//   pix_sof    first pixel of a frame (qualified by pix_valid)
//   pix_ready  the feeder accepts a pixel this cycle
//   request    consumer asks for the next row (one row per high cycle)
//   ready      one-cycle pulse; o_data / o_sof / line_id are valid
//   o_data     packed row; pixel k at bits [(k+1)*PIX_W-1 : k*PIX_W]
//   o_sof      the delivered row is row 0 of a frame
//   line_id    row index within the frame
//   err        sticky; set by a mid-row sof or by an extra request while one is pending
module pixel_feeder #(
  parameter int PIX_W  = 8,
  parameter int PIX_N  = 96,
  parameter int LINE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
  input  logic                   pix_sof,
  output logic                   pix_ready,
  input  logic                   request,
  output logic                   ready,
  output logic [PIX_W*PIX_N-1:0] o_data,
  output logic                   o_sof,
  output logic [LINE_W-1:0]      line_id,
  output logic                   err
);

  localparam int CW = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(PIX_N - 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t state, next_state;

  logic [PIX_W-1:0]  mem [2][PIX_N];
  logic [1:0]        full, full_nxt;
  logic [1:0]        buf_sof;
  logic [LINE_W-1:0] buf_line [2];
  logic [CW-1:0]     col;
  logic              wr_sel, rd_sel;
  logic [LINE_W-1:0] row_cnt;

  logic              accept, row_done, deliver, req_err;
  logic [CW-1:0]     col_eff;
  logic [LINE_W-1:0] row_eff;
  logic [PIX_W*PIX_N-1:0] rd_row;

  assign pix_ready = ~full[wr_sel];
  assign accept    = pix_valid & pix_ready;

  // A start-of-frame pixel always lands in column 0 of row 0. Any partial
  // row in progress is abandoned.
  assign col_eff  = pix_sof ? '0 : col;
  assign row_eff  = pix_sof ? '0 : row_cnt;
  assign row_done = accept && (col_eff == LAST_COL);

  for (genvar k = 0; k < PIX_N; k++) begin : g_pack
    assign rd_row[k*PIX_W +: PIX_W] = mem[rd_sel][k];
  end

  // Output FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic and the decision to release a row.
  // A row is never released while ready is already high, so that two pulses
  // cannot occur back to back. A request made in that cycle waits in PEND.
  always_comb begin
    next_state = state;
    deliver    = 1'b0;
    req_err    = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          if (full[rd_sel] && !ready) deliver    = 1'b1;
          else                        next_state = PEND;
        end
      end
      PEND: begin
        if (request) req_err = 1'b1;
        if (full[rd_sel] && !ready) begin
          deliver    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The row completion and the row release always touch different buffers.
  // Both updates are therefore applied to the flag vector.
  always_comb begin
    full_nxt = full;
    if (deliver)  full_nxt[rd_sel] = 1'b0;
    if (row_done) full_nxt[wr_sel] = 1'b1;
  end

  // Pixel storage. It needs no reset because a full flag guards every read.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_sel][col_eff] <= pix_data;
  end

  // Write-side bookkeeping, buffer flags and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full        <= '0;
      buf_sof     <= '0;
      buf_line[0] <= '0;
      buf_line[1] <= '0;
      col         <= '0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      row_cnt     <= '0;
      ready       <= 1'b0;
      o_data      <= '0;
      o_sof       <= 1'b0;
      line_id     <= '0;
      err         <= 1'b0;
    end else begin
      full  <= full_nxt;
      ready <= deliver;
      if (deliver) begin
        o_data  <= rd_row;
        o_sof   <= buf_sof[rd_sel];
        line_id <= buf_line[rd_sel];
        rd_sel  <= ~rd_sel;
      end
      if (accept) begin
        if (pix_sof) begin
          buf_sof[wr_sel] <= 1'b1;
          if (col != '0) err <= 1'b1;
        end else if (col == '0) begin
          buf_sof[wr_sel] <= 1'b0;
        end
        if (col_eff == LAST_COL) begin
          buf_line[wr_sel] <= row_eff;
          col              <= '0;
          wr_sel           <= ~wr_sel;
          row_cnt          <= row_eff + 1'b1;
        end else begin
          col     <= col_eff + 1'b1;
          row_cnt <= row_eff;
        end
      end
      if (req_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_feeder.sv
// tb_pixel_feeder
// Self-checking bench for pixel_feeder. It has three parts:
//   - a table of directed row scenarios
//   - hand-written multi-cycle sequences
//   - a randomized run checked against a row-queue reference model
module tb_pixel_feeder;

  localparam int PIX_W  = 8;
  localparam int PIX_N  = 96;
  localparam int LINE_W = 8;
  localparam int ROW_W  = PIX_W * PIX_N;

  logic              clk;
  logic              rst;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_sof;
  logic              pix_ready;
  logic              request;
  logic              ready;
  logic [ROW_W-1:0]  o_data;
  logic              o_sof;
  logic [LINE_W-1:0] line_id;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;

  pixel_feeder #(.PIX_W(PIX_W), .PIX_N(PIX_N), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .request(request), .ready(ready), .o_data(o_data), .o_sof(o_sof),
    .line_id(line_id), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed scenario record:
  //   - pre:   pixels sent before the frame's sof
  //   - rows:  full rows streamed
  //   - stall: cycles of blocked pixel attempts
  //   - the expected pix_ready after streaming and the expected err
  typedef struct {
    int   pre;
    int   rows;
    int   stall;
    logic exp_pix_ready;
    logic exp_err;
    int   seed;
  } vec_t;

  // Reference model: a list of completed rows in arrival order, plus the
  // row currently being assembled.
  typedef struct {
    logic [ROW_W-1:0]  data;
    logic              sof;
    logic [LINE_W-1:0] line;
  } row_t;

  row_t              m_rows[$];
  logic [ROW_W-1:0]  m_cur;
  int                m_col;
  logic              m_cur_sof;
  int                m_row_cnt;
  bit                m_pend;
  logic              exp_ready, exp_sof, exp_err;
  logic [ROW_W-1:0]  exp_data;
  logic [LINE_W-1:0] exp_line;

  task automatic checkOutput(input string name, input logic [ROW_W-1:0] act,
                             input logic [ROW_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive inputs for one cycle. The task returns at the next falling edge,
  // where outputs are sampled.
  task automatic applyStimulus(input logic v, input logic [PIX_W-1:0] d,
                               input logic s, input logic q);
    pix_valid = v;
    pix_data  = d;
    pix_sof   = s;
    request   = q;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; request = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [PIX_W-1:0] pixVal(input int seed, input int r, input int k);
    return PIX_W'(seed + r * 37 + k);
  endfunction

  function automatic logic [ROW_W-1:0] expRow(input int seed, input int r);
    logic [ROW_W-1:0] row;
    row = '0;
    for (int k = 0; k < PIX_N; k++) row[k*PIX_W +: PIX_W] = pixVal(seed, r, k);
    return row;
  endfunction

  task automatic streamRow(input int seed, input int r, input logic sof_first);
    for (int k = 0; k < PIX_N; k++)
      applyStimulus(1'b1, pixVal(seed, r, k), sof_first && (k == 0), 1'b0);
  endtask

  task automatic modelReset();
    m_rows.delete();
    m_cur = '0; m_col = 0; m_cur_sof = 1'b0; m_row_cnt = 0; m_pend = 1'b0;
    exp_ready = 1'b0; exp_sof = 1'b0; exp_err = 1'b0; exp_data = '0; exp_line = '0;
  endtask

  // Advance the model by one clock. It uses the cycle's inputs and the state
  // held at the start of the cycle.
  task automatic modelStep(input logic v, input logic [PIX_W-1:0] d,
                           input logic s, input logic q);
    bit   can_take, deliver;
    row_t rr;
    can_take = (m_rows.size() < 2);
    deliver  = 1'b0;
    if (!m_pend) begin
      if (q) begin
        if (m_rows.size() > 0 && !exp_ready) deliver = 1'b1;
        else m_pend = 1'b1;
      end
    end else begin
      if (q) exp_err = 1'b1;
      if (m_rows.size() > 0 && !exp_ready) begin
        deliver = 1'b1;
        m_pend  = 1'b0;
      end
    end
    if (deliver) begin
      rr = m_rows.pop_front();
      exp_data = rr.data; exp_sof = rr.sof; exp_line = rr.line;
    end
    exp_ready = deliver;
    if (v && can_take) begin
      if (s) begin
        if (m_col != 0) exp_err = 1'b1;
        m_col = 0; m_row_cnt = 0; m_cur_sof = 1'b1;
      end else if (m_col == 0) begin
        m_cur_sof = 1'b0;
      end
      m_cur[m_col*PIX_W +: PIX_W] = d;
      m_col++;
      if (m_col == PIX_N) begin
        rr.data = m_cur; rr.sof = m_cur_sof; rr.line = LINE_W'(m_row_cnt);
        m_rows.push_back(rr);
        m_row_cnt = (m_row_cnt + 1) % (1 << LINE_W);
        m_col = 0;
      end
    end
  endtask

  initial begin
    vec_t vecs[4];
    int   pulses;
    logic v, s, q;
    logic [PIX_W-1:0] d;

    vecs[0] = '{0,  1, 0, 1'b1, 1'b0, 0};
    vecs[1] = '{40, 1, 0, 1'b1, 1'b1, 5};
    vecs[2] = '{0,  2, 4, 1'b0, 1'b0, 9};
    vecs[3] = '{95, 1, 0, 1'b1, 1'b1, 77};

    // Reset values while reset is held
    rst = 1'b0;
    pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; request = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_pix_ready", pix_ready, 1);
    checkOutput("rst_o_data", o_data, 0);
    checkOutput("rst_o_sof", o_sof, 0);
    checkOutput("rst_line_id", line_id, 0);
    rst = 1'b1;
    @(negedge clk);

    // Table of directed row scenarios
    for (int i = 0; i < 4; i++) begin
      doReset();
      for (int k = 0; k < vecs[i].pre; k++)
        applyStimulus(1'b1, PIX_W'(8'hC0 + k), k == 0, 1'b0);
      for (int r = 0; r < vecs[i].rows; r++)
        streamRow(vecs[i].seed, r, r == 0);
      checkOutput($sformatf("vec%0d_pix_ready", i), pix_ready, vecs[i].exp_pix_ready);
      for (int st = 0; st < vecs[i].stall; st++)
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
      for (int r = 0; r < vecs[i].rows; r++) begin
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput($sformatf("vec%0d_row%0d_ready", i, r), ready, 1);
        checkOutput($sformatf("vec%0d_row%0d_data", i, r), o_data, expRow(vecs[i].seed, r));
        checkOutput($sformatf("vec%0d_row%0d_sof", i, r), o_sof, (r == 0));
        checkOutput($sformatf("vec%0d_row%0d_line", i, r), line_id, r);
        checkOutput($sformatf("vec%0d_row%0d_err", i, r), err, vecs[i].exp_err);
        checkOutput($sformatf("vec%0d_row%0d_pix_ready", i, r), pix_ready, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput($sformatf("vec%0d_row%0d_pulse", i, r), ready, 0);
      end
    end

    // Request before any pixel: ready arrives one cycle after the last write
    doReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("pend_no_ready", ready, 0);
    streamRow(11, 0, 1'b1);
    checkOutput("pend_ready_early", ready, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("pend_ready", ready, 1);
    checkOutput("pend_data", o_data, expRow(11, 0));
    checkOutput("pend_line", line_id, 0);
    checkOutput("pend_sof", o_sof, 1);
    checkOutput("pend_err", err, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("pend_single_pulse", ready, 0);

    // A second request while pending flags err and yields only one row
    doReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("dbl_req_err", err, 1);
    pulses = 0;
    for (int k = 0; k < PIX_N; k++) begin
      applyStimulus(1'b1, pixVal(3, 0, k), k == 0, 1'b0);
      if (ready) pulses++;
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      if (ready) pulses++;
    end
    checkOutput("dbl_req_pulses", pulses, 1);
    checkOutput("dbl_req_data", o_data, expRow(3, 0));

    // Reset mid-row clears outputs, the pending request and the partial row
    doReset();
    streamRow(30, 0, 1'b1);
    streamRow(30, 1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("mid_pre_line", line_id, 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 50; k++) applyStimulus(1'b1, pixVal(40, 0, k), k == 0, 1'b0);
    checkOutput("mid_pre_err", err, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_ready", ready, 0);
    checkOutput("mid_rst_err", err, 0);
    checkOutput("mid_rst_o_data", o_data, 0);
    checkOutput("mid_rst_o_sof", o_sof, 0);
    checkOutput("mid_rst_line", line_id, 0);
    checkOutput("mid_rst_pix_ready", pix_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    streamRow(21, 0, 1'b1);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      if (ready) pulses++;
    end
    checkOutput("mid_no_stale_pulse", pulses, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("mid_after_ready", ready, 1);
    checkOutput("mid_after_data", o_data, expRow(21, 0));
    checkOutput("mid_after_line", line_id, 0);
    checkOutput("mid_after_sof", o_sof, 1);

    // Randomized traffic against the reference model
    doReset();
    modelReset();
    for (int c = 0; c < 4000; c++) begin
      checkOutput("rnd_ready", ready, exp_ready);
      checkOutput("rnd_err", err, exp_err);
      checkOutput("rnd_pix_ready", pix_ready, (m_rows.size() < 2));
      checkOutput("rnd_o_data", o_data, exp_data);
      checkOutput("rnd_o_sof", o_sof, exp_sof);
      checkOutput("rnd_line_id", line_id, exp_line);
      v = ($urandom_range(0, 9) < 8);
      d = PIX_W'($urandom);
      s = (m_col == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 999) == 0);
      q = ($urandom_range(0, 119) == 0);
      modelStep(v, d, s, q);
      applyStimulus(v, d, s, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
